// File: rtl/onehot_index_fifo.sv
// rtl/onehot_index_fifo.sv - one-hot code checker, 3-bit re-encoder and index FIFO
// Optional per-index hit histogram is built when ONEHOT_INDEX_HIST_EN is defined.
module onehot_index_fifo #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_idx,
  output logic [$clog2(DEPTH):0]   count,
  output logic [ERR_W-1:0]         err_cnt,
  output logic                     err_flag
`ifdef ONEHOT_INDEX_HIST_EN
  ,
  input  logic [2:0]               hist_sel,
  output logic [7:0]               hist_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;

  logic       legal;
  logic [2:0] enc_idx;
  logic       accept, push, pop, bad;

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  always_comb begin
    legal   = (in_data != 8'h00) && ((in_data & (in_data - 8'd1)) == 8'h00);
    enc_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (in_data[k]) enc_idx = 3'(k);
    end
  end

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_idx   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign err_cnt   = err_cnt_q;
  assign err_flag  = err_flag_q;

  assign accept = in_valid & in_ready;
  assign push   = accept & legal;
  assign bad    = accept & ~legal;
  assign pop    = out_valid & out_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bad) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Storage is not reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_idx;
  end

`ifdef ONEHOT_INDEX_HIST_EN
  logic [7:0] hist_q [8];

  assign hist_cnt = hist_q[hist_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < 8; h++) hist_q[h] <= 8'd0;
    end else if (push && hist_q[enc_idx] != 8'hFF) begin
      hist_q[enc_idx] <= hist_q[enc_idx] + 8'd1;
    end
  end
`endif

endmodule
